// File: rtl/gat_pkg.sv
// Shared constants and types for the GAT host-side feature reader.
package gat_pkg;

    localparam int FEAT_WIDTH_DEFAULT = 32;
    localparam int FEAT_DEPTH_DEFAULT = 43328;
    localparam int BYTE_ADDR_SHIFT    = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rd_state_t;

endpackage

// File: rtl/feat_rd_fifo.sv
// Synchronous FIFO carrying {last, data}; read data is forced to zero when empty.
module feat_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gat_feat_reader.sv
// Sweeps the feature BRAM after gat_ready rises and streams every word out with tlast.
// Optional running checksum of streamed words when FEAT_RD_CHECKSUM_EN is defined.
module gat_feat_reader
    import gat_pkg::*;
#(
    parameter int NEW_FEATURE_WIDTH  = FEAT_WIDTH_DEFAULT,
    parameter int NEW_FEATURE_DEPTH  = FEAT_DEPTH_DEFAULT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int BRAM_RD_LATENCY    = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          rd_busy,
    output logic                          rd_done,
    output logic [31:0]                   rd_checksum
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + BRAM_RD_LATENCY + 1) + 1;
    localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

    rd_state_t                     state, state_next;
    logic                          gat_ready_q;
    logic                          start_sweep;
    logic                          issue;
    logic                          credit_ok;
    logic                          pop;
    logic                          push;
    logic [NEW_FEATURE_ADDR_W-1:0] rd_idx;
    logic [NEW_FEATURE_ADDR_W+1:0] cur_addr;
    logic [NEW_FEATURE_ADDR_W+1:0] addr_q;
    logic [BRAM_RD_LATENCY-1:0]    lat_vld;
    logic [BRAM_RD_LATENCY-1:0]    lat_last;
    logic [CNT_W-1:0]              occupancy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;

    assign start_sweep = (state == IDLE) & gat_ready & ~gat_ready_q;
    assign m_tvalid    = ~fifo_empty;
    assign pop         = m_tvalid & m_tready;
    assign push        = lat_vld[BRAM_RD_LATENCY-1];

    // Every issued read and every buffered word holds a FIFO slot until popped.
    assign occupancy = CNT_W'($countones(lat_vld)) + CNT_W'(fifo_count) - CNT_W'(pop);
    assign credit_ok = occupancy < CNT_W'(FIFO_DEPTH);

    assign cur_addr        = (NEW_FEATURE_ADDR_W+2)'(rd_idx) << BYTE_ADDR_SHIFT;
    assign feat_bram_addrb = issue ? cur_addr : addr_q;
    assign rd_busy         = (state == READ) | (state == DRAIN);
    assign rd_done         = (state == DONE);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:  if (start_sweep) state_next = READ;
            READ: begin
                issue = credit_ok;
                if (credit_ok && rd_idx == LAST_IDX) state_next = DRAIN;
            end
            DRAIN: if (pop && m_tlast) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gat_ready_q <= 1'b0;
            rd_idx      <= '0;
            addr_q      <= '0;
            lat_vld     <= '0;
            lat_last    <= '0;
        end else begin
            state       <= state_next;
            gat_ready_q <= gat_ready;
            if (start_sweep) begin
                rd_idx <= '0;
            end else if (issue && rd_idx != LAST_IDX) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (issue) begin
                addr_q <= cur_addr;
            end
            lat_vld[0]  <= issue;
            lat_last[0] <= issue & (rd_idx == LAST_IDX);
            for (int i = 1; i < BRAM_RD_LATENCY; i++) begin
                lat_vld[i]  <= lat_vld[i-1];
                lat_last[i] <= lat_last[i-1];
            end
        end
    end

    feat_rd_fifo #(
        .WIDTH (NEW_FEATURE_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({lat_last[BRAM_RD_LATENCY-1], feat_bram_dout}),
        .pop       (pop),
        .pop_data  ({m_tlast, m_tdata}),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

`ifdef FEAT_RD_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (start_sweep) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + 32'(m_tdata);
        end
    end

    assign rd_checksum = csum_q;
`else
    assign rd_checksum = '0;
`endif

endmodule

// File: tb/tb_gat_feat_reader.sv
// Randomised self-checking bench for gat_feat_reader with a latency-2 BRAM model (dout = 0x100 + index).
module tb_gat_feat_reader;

    localparam int DEPTH  = 8;
    localparam int LAT    = 2;
    localparam int FDEPTH = 4;
    localparam int AW     = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          gat_ready;
    logic [AW+1:0] feat_bram_addrb;
    logic [31:0]   feat_bram_dout;
    logic [31:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          rd_busy;
    logic          rd_done;
    logic [31:0]   rd_checksum;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model state
    int          expIdx;
    int          hsCount;
    logic [31:0] expSum;
    logic        doneExp;
    logic        prevStall;
    logic [31:0] prevData;
    logic        prevLast;

    logic [AW+1:0] addrP1, addrP2;

    always #5 clk = ~clk;

    gat_feat_reader #(
        .NEW_FEATURE_WIDTH (32),
        .NEW_FEATURE_DEPTH (DEPTH),
        .BRAM_RD_LATENCY   (LAT),
        .FIFO_DEPTH        (FDEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gat_ready       (gat_ready),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .rd_busy         (rd_busy),
        .rd_done         (rd_done),
        .rd_checksum     (rd_checksum)
    );

    // BRAM with two cycles of read latency
    always @(posedge clk) begin
        addrP1 <= feat_bram_addrb;
        addrP2 <= addrP1;
    end
    assign feat_bram_dout = 32'h100 + 32'(addrP2 >> 2);

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic newSweep();
        expIdx    = 0;
        hsCount   = 0;
        expSum    = '0;
        doneExp   = 1'b0;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
    endtask

    // Sets inputs for the coming rising edge, then checks the cycle it closes.
    task automatic applyStimulus(input logic ready, input logic gr);
        logic [31:0] expWord;
        m_tready  = ready;
        gat_ready = gr;
        #1;
        checkOutput("rd_done", rd_done, doneExp);
        doneExp = 1'b0;
        if (prevStall) begin
            checkOutput("hold_valid", m_tvalid, 1);
            checkOutput("hold_data", m_tdata, prevData);
            checkOutput("hold_last", m_tlast, prevLast);
        end
        if (m_tvalid && m_tready) begin
            if (expIdx >= DEPTH) begin
                checkOutput("extra_word", 64'(expIdx), 64'(DEPTH - 1));
            end else begin
                expWord = 32'h100 + 32'(expIdx);
                checkOutput("tdata", m_tdata, expWord);
                checkOutput("tlast", m_tlast, expIdx == DEPTH - 1);
`ifdef FEAT_RD_CHECKSUM_EN
                expSum = expSum + expWord;
`endif
                doneExp = (expIdx == DEPTH - 1);
            end
            expIdx++;
            hsCount++;
        end
        prevStall = m_tvalid & ~m_tready;
        prevData  = m_tdata;
        prevLast  = m_tlast;
    endtask

    task automatic dropGat();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    // mode 0: ready held high, 1: alternating, 2: random
    task automatic finishSweep(input int mode, input int budget);
        logic seen = 1'b0;
        logic r;
        for (int c = 0; c < budget && !seen; c++) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(c % 2) : logic'($urandom_range(0, 1));
            applyStimulus(r, 1'b1);
            if (rd_done) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("sweep_done", seen, 1);
        checkOutput("word_count", 64'(hsCount), 64'(DEPTH));
        checkOutput("checksum", rd_checksum, expSum);
    endtask

    initial begin
        rst_n     = 1'b0;
        gat_ready = 1'b0;
        m_tready  = 1'b0;
        newSweep();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_tvalid", m_tvalid, 0);
        checkOutput("rst_addrb", feat_bram_addrb, 0);
        checkOutput("rst_busy", rd_busy, 0);
        checkOutput("rst_checksum", rd_checksum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dropGat();

        // Basic sweep with fixed latency and address expectations
        $display("[TB] basic sweep");
        newSweep();
        for (int s = 0; s <= 13; s++) begin
            applyStimulus(1'b1, 1'b1);
            if (s >= 1 && s <= DEPTH) checkOutput("addrb_step", feat_bram_addrb, 64'(4 * (s - 1)));
            checkOutput("tvalid_timing", m_tvalid, (s >= 4 && s <= 11));
            checkOutput("busy_timing", rd_busy, (s >= 1 && s <= 11));
            @(negedge clk);
        end
        checkOutput("word_count", 64'(hsCount), 64'(DEPTH));
        checkOutput("checksum", rd_checksum, expSum);
`ifdef FEAT_RD_CHECKSUM_EN
        checkOutput("checksum_const", rd_checksum, 32'h81C);
`endif

        // Holding gat_ready high must not retrigger
        $display("[TB] retrigger hold");
        for (int s = 0; s < 8; s++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("retrig_busy", rd_busy, 0);
            checkOutput("retrig_tvalid", m_tvalid, 0);
            @(negedge clk);
        end
        dropGat();

        // Back-pressure from the start: only FIFO_DEPTH reads may be issued
        $display("[TB] back-pressure");
        newSweep();
        for (int s = 0; s <= 10; s++) begin
            applyStimulus(1'b0, 1'b1);
            if (s >= 1 && s <= FDEPTH) checkOutput("bp_addrb_step", feat_bram_addrb, 64'(4 * (s - 1)));
            if (s > FDEPTH) checkOutput("bp_addrb_frozen", feat_bram_addrb, 64'(4 * (FDEPTH - 1)));
            if (s >= 4) checkOutput("bp_tvalid", m_tvalid, 1);
            @(negedge clk);
        end
        finishSweep(1, 200);
        dropGat();

        // Random ready with stability checks
        $display("[TB] random ready");
        newSweep();
        finishSweep(2, 400);
        dropGat();

        // Reset in the middle of a sweep
        $display("[TB] reset mid-sweep");
        newSweep();
        for (int c = 0; c < 100 && expIdx < 4; c++) begin
            applyStimulus(1'b1, 1'b1);
            @(negedge clk);
        end
        checkOutput("pre_reset_words", 64'(expIdx), 4);
        rst_n     = 1'b0;
        gat_ready = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", m_tvalid, 0);
        checkOutput("mid_rst_tdata", m_tdata, 0);
        checkOutput("mid_rst_tlast", m_tlast, 0);
        checkOutput("mid_rst_addrb", feat_bram_addrb, 0);
        checkOutput("mid_rst_busy", rd_busy, 0);
        checkOutput("mid_rst_done", rd_done, 0);
        checkOutput("mid_rst_checksum", rd_checksum, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        newSweep();
        dropGat();
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("post_rst_idle", m_tvalid, 0);
            @(negedge clk);
        end
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        checkOutput("restart_addrb", feat_bram_addrb, 0);
        @(negedge clk);
        finishSweep(0, 100);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/gat_feat_reader.md
Name: gat_feat_reader

Overview:
- Host-side reader for the new-feature BRAM read port of the GAT top.
- After the accelerator raises gat_ready, sweeps the whole feature BRAM by byte address and absorbs the BRAM read latency.
- Delivers every word in address order on a valid/ready stream with a last marker, toward the DMA/PS path.
- Back-pressure-safe: a read is never issued unless FIFO space is reserved for its data.

Parameters:
- NEW_FEATURE_WIDTH, 32, feature word width.
- NEW_FEATURE_DEPTH, 43328, words to read (NUM_SUBGRAPHS*NUM_FEATURE_OUT).
- NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), word-address width.
- BRAM_RD_LATENCY, 2, cycles from addrb to valid dout (1..4).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, >= BRAM_RD_LATENCY+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- gat_ready  in  1  level from accelerator; rising edge starts a sweep
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address (word index << 2, bits [1:0]=0)
- feat_bram_dout  in  NEW_FEATURE_WIDTH  BRAM read data
- m_tdata  out  NEW_FEATURE_WIDTH  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast  out  1  high with word NEW_FEATURE_DEPTH-1
- rd_busy  out  1  high from READ through DRAIN
- rd_done  out  1  one-cycle pulse after last handshake
- rd_checksum  out  32  see Optional Feature

Behaviour:
- Reset: all outputs 0; state IDLE; counters, FIFO, pipeline valids cleared. Reset mid-sweep aborts; in-flight BRAM data is discarded.
- Edge detect: gat_ready registered; start = gat_ready & ~gat_ready_q. Edges outside IDLE are ignored. gat_ready must fall and rise again for a new sweep.
- FSM:
  - IDLE -> READ on start.
  - READ: issue when credit available; after issuing index DEPTH-1 -> DRAIN.
  - DRAIN -> DONE on the handshake of the last word.
  - DONE: rd_done=1 for one cycle -> IDLE.
- Credit rule: issue allowed iff inflight + fifo_count + (pop this cycle ? -1 : 0) < FIFO_DEPTH.
  - inflight = valid bits in a BRAM_RD_LATENCY-deep shift register.
  - Issue increments the read index; addrb holds the last issued address otherwise.
- Data capture: dout sampled when the valid bit exits the shift register, pushed into the FIFO the same cycle.
  - The credit rule guarantees no overflow; overflow is an assertion failure.
- Latency: start seen in cycle T; addr 0 presented in T+1; dout captured end of T+1+L; m_tvalid in T+2+L (T+4 at L=2).
- Throughput: one word per cycle when m_tready is held high and FIFO_DEPTH >= L+1.
- Stream rules:
  - m_tdata and m_tlast stay stable while m_tvalid & ~m_tready.
  - m_tvalid never drops without a handshake.
  - m_tlast travels in the FIFO alongside the data; its FIFO bit is 1 iff index == DEPTH-1.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Index counter stops at DEPTH-1 and does not wrap.
- rd_busy = READ | DRAIN.

Optional Feature:
- Macro: FEAT_RD_CHECKSUM_EN.
- Defined: rd_checksum accumulates the mod-2^32 sum of the zero-extended m_tdata on each handshake.
  - Cleared on start.
  - Holds its value after DONE until the next start.
- Undefined: rd_checksum tied to 0; no accumulator logic.

Decomposition:
- gat_pkg holds:
  - NEW_FEATURE_WIDTH/DEPTH defaults.
  - The byte-address shift constant (2).
  - The rd_state_t enum (IDLE, READ, DRAIN, DONE).
- One sub-module: feat_rd_fifo, a synchronous FIFO with width NEW_FEATURE_WIDTH+1 (data+last) and outputs count/full/empty.
- Credit logic, FSM and latency shift register stay in gat_feat_reader.

Test Plan (DEPTH=8, L=2, FIFO_DEPTH=4, dout = 0x100+index):
- Basic sweep: m_tready=1, pulse gat_ready at T -> m_tvalid first in T+4; tdata 0x100..0x107 on consecutive cycles; tlast with 0x107; rd_done one cycle after; addrb steps 0x00,0x04..0x1C.
- Back-pressure: m_tready=0 from start -> exactly 4 reads issued, addrb frozen at 0x0C, no data lost. Then toggle m_tready 1/0 -> all 8 words in order, no drops or duplicates.
- Retrigger: hold gat_ready high through and after DONE -> no second sweep. Drop it and raise again -> a new sweep from addrb=0.
- Reset mid-sweep: assert rst_n=0 after word 3 is accepted -> all outputs 0 immediately. After release, a gat_ready edge restarts from index 0 with no stale data.
- Checksum (FEAT_RD_CHECKSUM_EN): full sweep -> rd_checksum = 0x81C. Without the macro -> rd_checksum stays 0.
- Stability check under random m_tready: tdata/tlast held while valid & ~ready; total handshakes = 8.
